// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Receives a program as a stream of bytes, assembles each group of four bytes
// (MSB first) into a 32-bit word and writes it to instruction RAM at
// consecutive addresses starting from 0. A session loads PROGRAM_LENGTH words
// and keeps a running XOR of every word written.
//
// Handshake: a byte is consumed on a rising clock edge where byteValid=1 and
// byteReady=1. byteReady is registered and is high only in RECEIVE, so a
// byte offered in any other state is neither consumed nor latched.
//
// Ports
//   clock      : single clock, rising-edge active
//   reset      : asynchronous, active-high reset
//   start      : begins a session when sampled high in IDLE or DONE
//   byteIn     : incoming program byte
//   byteValid  : byteIn is valid this cycle
//   byteReady  : loader accepts a byte this cycle (RECEIVE only)
//   wrEnable   : one-cycle write strobe to instruction RAM
//   wrAddress  : instruction RAM write address
//   wrData     : word being written; holds the last assembled word otherwise
//   busy       : high in RECEIVE and WRITE
//   done       : high in DONE
//   checksum   : XOR of all words written in the current session
//   dbg_state  : current FSM state (0 IDLE, 1 RECEIVE, 2 WRITE, 3 DONE)
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int PROGRAM_LENGTH = 27,
    parameter int ADDRESS_WIDTH  = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               byteIn,
    input  logic                     byteValid,
    output logic                     byteReady,
    output logic                     wrEnable,
    output logic [ADDRESS_WIDTH-1:0] wrAddress,
    output logic [31:0]              wrData,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              checksum,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECEIVE = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(PROGRAM_LENGTH - 1);

    state_t                     state_q,      state_d;
    logic [1:0]                 byte_idx_q,   byte_idx_d;
    logic [31:0]                word_q,       word_d;
    logic [ADDRESS_WIDTH-1:0]   wr_addr_q,    wr_addr_d;
    logic [31:0]                wr_data_q,    wr_data_d;
    logic [31:0]                checksum_q,   checksum_d;
    logic                       byte_ready_q, byte_ready_d;
    logic                       wr_enable_q,  wr_enable_d;
    logic                       busy_q,       busy_d;
    logic                       done_q,       done_d;

    logic                       byte_fire;
    logic [31:0]                word_shifted;

    assign byte_fire    = byte_ready_q & byteValid;
    assign word_shifted = {word_q[23:0], byteIn};

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RECEIVE;
                    wr_addr_d  = '0;
                    byte_idx_d = 2'd0;
                    word_d     = '0;
                    checksum_d = '0;
                end
            end

            S_RECEIVE: begin
                // Idle cycles hold everything; there is deliberately no timeout.
                if (byte_fire) begin
                    word_d     = word_shifted;
                    byte_idx_d = byte_idx_q + 2'd1;   // wraps 3 -> 0
                    if (byte_idx_q == 2'd3) begin
                        // Capture the complete word so wrData is valid in WRITE
                        // and keeps it while the next word is assembled.
                        wr_data_d = word_shifted;
                        state_d   = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                checksum_d = checksum_q ^ wr_data_q;
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = S_RECEIVE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: decode them from the next state so they line
        // up with the state register.
        byte_ready_d = (state_d == S_RECEIVE);
        wr_enable_d  = (state_d == S_WRITE);
        busy_d       = (state_d == S_RECEIVE) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            word_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            checksum_q   <= '0;
            byte_ready_q <= 1'b0;
            wr_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            checksum_q   <= checksum_d;
            byte_ready_q <= byte_ready_d;
            wr_enable_q  <= wr_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byteReady = byte_ready_q;
    assign wrEnable  = wr_enable_q;
    assign wrAddress = wr_addr_q;
    assign wrData    = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//
// Two loaders share one stimulus stream: dut_a uses the default program
// length (27 words), dut_b is built with a 2-word program so session end,
// DONE and restart can be exercised quickly. A cycle-by-cycle vector table
// covers first-word latency and the ready/valid behaviour around WRITE;
// hand-written sequences cover reset mid-word, gapped transfers, restart from
// DONE and a full 27-word load. Writes are checked against per-DUT expected
// queues of {address, data}.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        rdy_a, wen_a, busy_a, done_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a, csum_a;
    logic [1:0]  st_a;

    logic        rdy_b, wen_b, busy_b, done_b;
    logic [9:0]  addr_b;
    logic [31:0] data_b, csum_b;
    logic [1:0]  st_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [41:0] exp_q_a[$];
    logic [41:0] exp_q_b[$];
    logic        mon_a_en = 1'b0;
    logic        mon_b_en = 1'b0;
    int          wr_cnt_a = 0;

    instruction_loader u_dut_a (
        .clock     (clk),
        .reset     (rst),
        .start     (start),
        .byteIn    (byte_in),
        .byteValid (byte_valid),
        .byteReady (rdy_a),
        .wrEnable  (wen_a),
        .wrAddress (addr_a),
        .wrData    (data_a),
        .busy      (busy_a),
        .done      (done_a),
        .checksum  (csum_a),
        .dbg_state (st_a)
    );

    instruction_loader #(.PROGRAM_LENGTH(2), .ADDRESS_WIDTH(10)) u_dut_b (
        .clock     (clk),
        .reset     (rst),
        .start     (start),
        .byteIn    (byte_in),
        .byteValid (byte_valid),
        .byteReady (rdy_b),
        .wrEnable  (wen_b),
        .wrAddress (addr_b),
        .wrData    (data_b),
        .busy      (busy_b),
        .done      (done_b),
        .checksum  (csum_b),
        .dbg_state (st_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        logic [41:0] e;
        if (mon_a_en && wen_a) begin
            wr_cnt_a++;
            if (exp_q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_a_unexpected: got addr=%0d data=%h, required no write", addr_a, data_a);
            end else begin
                e = exp_q_a.pop_front();
                check("write_a_addr", 32'(addr_a), 32'(e[41:32]));
                check("write_a_data", data_a, e[31:0]);
            end
        end
        if (mon_b_en && wen_b) begin
            if (exp_q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_b_unexpected: got addr=%0d data=%h, required no write", addr_b, data_b);
            end else begin
                e = exp_q_b.pop_front();
                check("write_b_addr", 32'(addr_b), 32'(e[41:32]));
                check("write_b_data", data_b, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte until dut_a accepts it (dut_b runs in lock-step whenever
    // both are receiving).
    task automatic send_byte(input logic [7:0] b);
        logic accepted;
        int   n;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 16) begin
            accepted = rdy_a;
            tick();
            n++;
        end
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_timeout: got no acceptance of %h in 16 cycles, required acceptance", b);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_byte(w[31 - 8*k -: 8]);
        end
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_rdy"},   32'(rdy_a),  32'd0);
        check({tag, "_wen"},   32'(wen_a),  32'd0);
        check({tag, "_addr"},  32'(addr_a), 32'd0);
        check({tag, "_data"},  data_a,      32'd0);
        check({tag, "_busy"},  32'(busy_a), 32'd0);
        check({tag, "_done"},  32'(done_a), 32'd0);
        check({tag, "_csum"},  csum_a,      32'd0);
        check({tag, "_state"}, 32'(st_a),   32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  b;
        logic        rdy;
        logic        wen;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic [31:0] csum;
    } vec_t;

    vec_t tbl[15];

    // ---------------- main test ----------------
    initial begin
        logic [31:0] w;
        logic [31:0] exp_csum;
        int          n;

        // start, valid, byte | rdy, wen, addr, data, busy, done, csum
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b0, 1'b1, 8'h6C, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 10'd0, 32'h6C000000, 1'b1, 1'b0, 32'h00000000};
        // valid held high through WRITE: 8'h11 must not be consumed
        tbl[5]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 10'd1, 32'h6C000000, 1'b1, 1'b0, 32'h6C000000};
        tbl[6]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 10'd1, 32'h6C000000, 1'b1, 1'b0, 32'h6C000000};
        tbl[7]  = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 10'd1, 32'h6C000000, 1'b1, 1'b0, 32'h6C000000};
        tbl[8]  = '{1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 10'd1, 32'h6C000000, 1'b1, 1'b0, 32'h6C000000};
        // start during RECEIVE is ignored
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd1, 32'h6C000000, 1'b1, 1'b0, 32'h6C000000};
        tbl[10] = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 10'd1, 32'h6C000000, 1'b1, 1'b0, 32'h6C000000};
        tbl[11] = '{1'b0, 1'b1, 8'h78, 1'b0, 1'b1, 10'd1, 32'h12345678, 1'b1, 1'b0, 32'h6C000000};
        tbl[12] = '{1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, 10'd2, 32'h12345678, 1'b1, 1'b0, 32'h7E345678};
        tbl[13] = '{1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 10'd2, 32'h12345678, 1'b1, 1'b0, 32'h7E345678};
        tbl[14] = '{1'b0, 1'b1, 8'hAD, 1'b1, 1'b0, 10'd2, 32'h12345678, 1'b1, 1'b0, 32'h7E345678};

        // ---- reset ----
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) tick();
        check_all_zero_a("reset");
        rst = 1'b0;
        tick();
        check("idle_rdy",  32'(rdy_a),  32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);

        // ---- cycle-by-cycle table on dut_a ----
        for (int i = 0; i < 15; i++) begin
            start      = tbl[i].start;
            byte_valid = tbl[i].valid;
            byte_in    = tbl[i].b;
            tick();
            check($sformatf("tbl%0d_rdy", i),  32'(rdy_a),  32'(tbl[i].rdy));
            check($sformatf("tbl%0d_wen", i),  32'(wen_a),  32'(tbl[i].wen));
            check($sformatf("tbl%0d_addr", i), 32'(addr_a), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_data", i), data_a,      tbl[i].data);
            check($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].done));
            check($sformatf("tbl%0d_csum", i), csum_a,      tbl[i].csum);
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        // dut_b (2 words) finished its session during the table
        check("b_done_after_tbl", 32'(done_b), 32'd1);
        check("b_busy_after_tbl", 32'(busy_b), 32'd0);
        check("b_addr_after_tbl", 32'(addr_b), 32'd1);
        check("b_csum_after_tbl", csum_b,      32'h7E345678);
        repeat (2) tick();
        check("b_done_hold", 32'(done_b), 32'd1);
        check("b_csum_hold", csum_b,      32'h7E345678);
        check("b_rdy_done",  32'(rdy_b),  32'd0);

        // start in DONE restarts dut_b; dut_a is mid-word and ignores it
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b_restart_done", 32'(done_b), 32'd0);
        check("b_restart_csum", csum_b,      32'd0);
        check("b_restart_addr", 32'(addr_b), 32'd0);
        check("b_restart_rdy",  32'(rdy_b),  32'd1);
        check("a_start_ignored_addr", 32'(addr_a), 32'd2);
        check("a_start_ignored_csum", csum_a,      32'h7E345678);

        // ---- asynchronous reset after 2 bytes of a word ----
        #2 rst = 1'b1;
        #1;
        check_all_zero_a("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        mon_a_en = 1'b1;
        mon_b_en = 1'b1;
        // bytes offered before a new start are not accepted
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        repeat (3) tick();
        byte_valid = 1'b0;
        check("post_reset_rdy",  32'(rdy_a),  32'd0);
        check("post_reset_busy", 32'(busy_a), 32'd0);
        check("post_reset_wen",  32'(wen_a),  32'd0);

        // ---- 2-word session with gaps ----
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q_a.push_back({10'd0, 32'h5400000B});
        exp_q_a.push_back({10'd1, 32'h68200005});
        exp_q_b.push_back({10'd0, 32'h5400000B});
        exp_q_b.push_back({10'd1, 32'h68200005});
        send_word(32'h5400000B, 3);
        send_word(32'h68200005, 3);
        n = 0;
        while (!done_b && n < 10) begin
            tick();
            n++;
        end
        check("b_session_done", 32'(done_b), 32'd1);
        check("b_session_csum", csum_b,      32'h3C20000E);
        check("a_session_csum", csum_a,      32'h3C20000E);
        check("a_session_addr", 32'(addr_a), 32'd2);
        check("a_session_done", 32'(done_a), 32'd0);
        check("session_q_a_empty", 32'(exp_q_a.size()), 32'd0);
        check("session_q_b_empty", 32'(exp_q_b.size()), 32'd0);

        // ---- restart from DONE: next write goes to address 0 ----
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b_restart2_done", 32'(done_b), 32'd0);
        check("b_restart2_csum", csum_b,      32'd0);
        exp_q_b.push_back({10'd0, 32'hA1B2C3D4});
        exp_q_a.push_back({10'd2, 32'hA1B2C3D4});
        send_word(32'hA1B2C3D4, 2);
        tick();
        check("restart_q_a_empty", 32'(exp_q_a.size()), 32'd0);
        check("restart_q_b_empty", 32'(exp_q_b.size()), 32'd0);
        check("b_restart2_csum_after", csum_b, 32'hA1B2C3D4);

        // ---- full 27-word load on dut_a ----
        mon_b_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q_a.delete();
        wr_cnt_a = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_csum = 32'd0;
        for (int i = 0; i < 27; i++) begin
            w = $urandom;
            exp_q_a.push_back({10'(i), w});
            exp_csum = exp_csum ^ w;
            send_word(w, 1);
        end
        // now in the WRITE cycle of the last word
        check("full_last_wen",  32'(wen_a),  32'd1);
        check("full_last_addr", 32'(addr_a), 32'd26);
        tick();
        check("full_done",      32'(done_a), 32'd1);
        check("full_done_wen",  32'(wen_a),  32'd0);
        check("full_done_busy", 32'(busy_a), 32'd0);
        check("full_done_addr", 32'(addr_a), 32'd26);
        check("full_csum",      csum_a,      exp_csum);
        tick();
        check("full_write_count", 32'(wr_cnt_a), 32'd27);
        check("full_q_empty",     32'(exp_q_a.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
